// File: rtl/pwm_axi_pkg.sv
// Shared constants and helpers for the AXI4-Lite PWM slave.
package pwm_axi_pkg;

    typedef logic [1:0] reg_idx_t;

    localparam reg_idx_t   REG_CTRL    = 2'd0;
    localparam reg_idx_t   REG_PERIOD  = 2'd1;
    localparam reg_idx_t   REG_DUTY    = 2'd2;
    localparam reg_idx_t   REG_COUNT   = 2'd3;

    localparam int         CTRL_EN_BIT = 0;
    localparam logic [1:0] RESP_OKAY   = 2'b00;

    // Merge new_val into old_val one byte lane at a time under strb.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/pwm_core.sv
// Single-channel PWM: up-counter with period/duty shadows that reload only at a
// period boundary (or continuously while idle), plus a registered output stage.
module pwm_core
    import pwm_axi_pkg::*;
(
    input  logic        clk_sys,
    input  logic        rst_b,
    input  logic        en,
    input  logic [31:0] period,
    input  logic [31:0] duty,
    output logic [31:0] cnt,
    output logic        pwm_out,
    output logic        period_done
);

    logic [31:0] period_act;
    logic [31:0] duty_act;
    logic        running;
    logic        last_cnt;

    assign running     = en && (period_act != 32'd0);
    assign last_cnt    = running && (cnt == period_act - 32'd1);
    assign period_done = last_cnt;

    always_ff @(posedge clk_sys) begin
        if (!rst_b) begin
            cnt        <= 32'd0;
            pwm_out    <= 1'b0;
            period_act <= 32'd0;
            duty_act   <= 32'd0;
        end else if (!running) begin
            // Idle: keep shadows tracking the registers so enabling starts clean.
            cnt        <= 32'd0;
            pwm_out    <= 1'b0;
            period_act <= period;
            duty_act   <= duty;
        end else begin
            pwm_out <= (cnt < duty_act);
            if (last_cnt) begin
                cnt        <= 32'd0;
                period_act <= period;
                duty_act   <= duty;
            end else begin
                cnt <= cnt + 32'd1;
            end
        end
    end

endmodule

// File: rtl/pwm_axi_slave.sv
// AXI4-Lite slave with a four-entry register file driving pwm_core.
// AW and W are buffered independently; the write fires once both are present.
module pwm_axi_slave
    import pwm_axi_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            pwm_out,
    output logic                            period_done
);

    logic        aw_ready_q, w_ready_q, ar_ready_q;
    logic        bvalid_q, rvalid_q;
    logic [31:0] rdata_q;

    logic        aw_held, w_held;
    reg_idx_t    aw_idx_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    logic        ctrl_en;
    logic [31:0] period_reg, duty_reg;
    logic [31:0] cnt;

    logic        aw_hs, w_hs, ar_hs, wr_fire;
    logic        aw_held_nxt, w_held_nxt, bvalid_nxt, rvalid_nxt;
    reg_idx_t    wr_idx;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic [31:0] rd_mux;
    logic        unused_ok;

    assign aw_hs   = S_AXI_AWVALID && aw_ready_q;
    assign w_hs    = S_AXI_WVALID  && w_ready_q;
    assign ar_hs   = S_AXI_ARVALID && ar_ready_q;
    assign wr_fire = (aw_held || aw_hs) && (w_held || w_hs);

    assign wr_idx  = aw_held ? aw_idx_q : S_AXI_AWADDR[3:2];
    assign wr_data = w_held  ? wdata_q  : S_AXI_WDATA;
    assign wr_strb = w_held  ? wstrb_q  : S_AXI_WSTRB;

    assign aw_held_nxt = !wr_fire && (aw_held || aw_hs);
    assign w_held_nxt  = !wr_fire && (w_held  || w_hs);
    assign bvalid_nxt  = wr_fire || (bvalid_q && !S_AXI_BREADY);
    assign rvalid_nxt  = ar_hs   || (rvalid_q && !S_AXI_RREADY);

    always_comb begin
        rd_mux = 32'd0;
        case (S_AXI_ARADDR[3:2])
            REG_CTRL:   rd_mux[CTRL_EN_BIT] = ctrl_en;
            REG_PERIOD: rd_mux = period_reg;
            REG_DUTY:   rd_mux = duty_reg;
            REG_COUNT:  rd_mux = cnt;
            default:    rd_mux = 32'd0;
        endcase
    end

    // Readies are registered so they are low throughout reset.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            ar_ready_q <= 1'b0;
            bvalid_q   <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= 32'd0;
            aw_held    <= 1'b0;
            w_held     <= 1'b0;
            aw_idx_q   <= REG_CTRL;
            wdata_q    <= 32'd0;
            wstrb_q    <= 4'd0;
        end else begin
            aw_held    <= aw_held_nxt;
            w_held     <= w_held_nxt;
            bvalid_q   <= bvalid_nxt;
            rvalid_q   <= rvalid_nxt;
            aw_ready_q <= !aw_held_nxt && !bvalid_nxt;
            w_ready_q  <= !w_held_nxt  && !bvalid_nxt;
            ar_ready_q <= !rvalid_nxt;
            if (aw_hs) aw_idx_q <= S_AXI_AWADDR[3:2];
            if (w_hs) begin
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
            if (ar_hs) rdata_q <= rd_mux;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            ctrl_en    <= 1'b0;
            period_reg <= 32'd0;
            duty_reg   <= 32'd0;
        end else if (wr_fire) begin
            case (wr_idx)
                REG_CTRL:   if (wr_strb[0]) ctrl_en <= wr_data[CTRL_EN_BIT];
                REG_PERIOD: period_reg <= apply_wstrb(period_reg, wr_data, wr_strb);
                REG_DUTY:   duty_reg   <= apply_wstrb(duty_reg, wr_data, wr_strb);
                default:    ;
            endcase
        end
    end

    pwm_core u_pwm_core (
        .clk_sys     (S_AXI_ACLK),
        .rst_b       (S_AXI_ARESETN),
        .en          (ctrl_en),
        .period      (period_reg),
        .duty        (duty_reg),
        .cnt         (cnt),
        .pwm_out     (pwm_out),
        .period_done (period_done)
    );

    assign S_AXI_AWREADY = aw_ready_q;
    assign S_AXI_WREADY  = w_ready_q;
    assign S_AXI_ARREADY = ar_ready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = RESP_OKAY;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = RESP_OKAY;

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_pwm_axi_slave.sv
// Directed bench for pwm_axi_slave: register access, strobes, channel ordering,
// PWM waveform with shadowed updates, boundary values and mid-operation reset.
module tb_pwm_axi_slave;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        pwm_out, period_done;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int t0;
    int j;
    int n;
    logic [31:0] rd;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pwm_axi_slave dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rstn),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .pwm_out       (pwm_out),
        .period_done   (period_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic aw_done, w_done, a_rdy, w_rdy;
        int k;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        aw_done = 1'b0; w_done = 1'b0; k = 0;
        while (!(aw_done && w_done) && k < 50) begin
            a_rdy = awready && !aw_done;
            w_rdy = wready && !w_done;
            step();
            if (a_rdy) begin aw_done = 1'b1; awvalid = 1'b0; end
            if (w_rdy) begin w_done = 1'b1; wvalid = 1'b0; end
            k++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        chk("wr_accept", {30'd0, aw_done, w_done}, 32'd3);
        k = 0;
        while (!bvalid && k < 50) begin step(); k++; end
        chk("wr_bvalid", {31'd0, bvalid}, 32'd1);
        chk("wr_bresp", {30'd0, bresp}, 32'd0);
        step();
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
        logic got;
        int k;
        araddr = addr; arvalid = 1'b1; got = 1'b0; k = 0;
        while (!got && k < 50) begin
            got = arready;
            step();
            k++;
        end
        arvalid = 1'b0;
        k = 0;
        while (!rvalid && k < 50) begin step(); k++; end
        chk("rd_rvalid", {31'd0, rvalid}, 32'd1);
        chk("rd_rresp", {30'd0, rresp}, 32'd0);
        data = rdata;
        rready = 1'b1;
        step();
        rready = 1'b0;
    endtask

    task automatic wait_period_done();
        int k;
        k = 0;
        while (!period_done && k < 40) begin step(); k++; end
        chk("sync_period_done", {31'd0, period_done}, 32'd1);
    endtask

    initial begin
        rstn = 1'b0;
        awaddr = 4'h0; araddr = 4'h0; awprot = 3'd0; arprot = 3'd0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arvalid = 1'b0; rready = 1'b0;
        wdata = 32'd0; wstrb = 4'h0;

        // Reset state
        repeat (3) step();
        chk("rst_awready", {31'd0, awready}, 32'd0);
        chk("rst_wready", {31'd0, wready}, 32'd0);
        chk("rst_arready", {31'd0, arready}, 32'd0);
        chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_pwm", {31'd0, pwm_out}, 32'd0);
        rstn = 1'b1;
        step();
        chk("rel_awready", {31'd0, awready}, 32'd1);
        chk("rel_wready", {31'd0, wready}, 32'd1);
        chk("rel_arready", {31'd0, arready}, 32'd1);

        // Write / readback
        axi_write(4'h0, 32'h1, 4'hF);
        axi_write(4'h4, 32'hA, 4'hF);
        axi_write(4'h8, 32'h3, 4'hF);
        axi_write(4'hC, 32'hFFFF, 4'hF);
        axi_read(4'h0, rd); chk("rb_ctrl", rd, 32'h1);
        axi_read(4'h4, rd); chk("rb_period", rd, 32'hA);
        axi_read(4'h8, rd); chk("rb_duty", rd, 32'h3);
        axi_read(4'hC, rd); chk("rb_count_range", {31'd0, (rd < 32'd10)}, 32'd1);

        // Byte strobes, PWM disabled
        axi_write(4'h0, 32'h0, 4'hF);
        axi_write(4'h4, 32'h11223344, 4'hF);
        axi_write(4'h4, 32'hAABBCCDD, 4'b0101);
        axi_read(4'h4, rd); chk("strobe_period", rd, 32'h11BB33DD);
        axi_write(4'h0, 32'hFFFF_FFFF, 4'b1110);
        axi_read(4'h0, rd); chk("strobe_ctrl_lane0_off", rd, 32'h0);

        // AW three cycles ahead of W, then B back-pressure
        bready = 1'b0;
        awaddr = 4'h4; wdata = 32'd10; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b0;
        chk("ooo_awready", {31'd0, awready}, 32'd1);
        step();
        awvalid = 1'b0;
        chk("ooo_aw_buffered", {31'd0, awready}, 32'd0);
        chk("ooo_wready_open", {31'd0, wready}, 32'd1);
        step();
        chk("ooo_no_b_yet", {31'd0, bvalid}, 32'd0);
        step();
        wvalid = 1'b1;
        chk("ooo_no_b_before_w", {31'd0, bvalid}, 32'd0);
        step();
        wvalid = 1'b0;
        chk("ooo_b_after_w", {31'd0, bvalid}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("bp_awready", {31'd0, awready}, 32'd0);
            chk("bp_wready", {31'd0, wready}, 32'd0);
            chk("bp_bvalid_hold", {31'd0, bvalid}, 32'd1);
            step();
        end
        bready = 1'b1;
        step();
        chk("bp_b_done", {31'd0, bvalid}, 32'd0);
        chk("bp_awready_back", {31'd0, awready}, 32'd1);
        chk("bp_wready_back", {31'd0, wready}, 32'd1);
        axi_read(4'h4, rd); chk("ooo_period", rd, 32'd10);

        // Waveform: PERIOD=10, DUTY=3
        axi_write(4'h8, 32'd3, 4'hF);
        axi_write(4'h0, 32'h1, 4'hF);
        wait_period_done();
        t0 = cyc;
        for (int k = 1; k <= 10; k++) begin
            step();
            j = cyc - t0;
            chk("wave_pd", {31'd0, period_done}, {31'd0, (j == 10)});
            chk("wave_pwm", {31'd0, pwm_out}, {31'd0, (j >= 2) && ((j - 2) < 3)});
        end
        t0 = cyc;
        // DUTY=7 lands mid-period; current period must keep duty 3
        repeat (5) step();
        axi_write(4'h8, 32'd7, 4'hF);
        j = cyc - t0;
        while (j <= 20) begin
            chk("mid_pd", {31'd0, period_done}, {31'd0, (j % 10) == 0});
            if (j <= 11)
                chk("mid_pwm_old", {31'd0, pwm_out}, {31'd0, ((j - 2) % 10) < 3});
            else
                chk("mid_pwm_new", {31'd0, pwm_out}, {31'd0, ((j - 2) % 10) < 7});
            step();
            j = cyc - t0;
        end

        // DUTY beyond PERIOD -> constant high
        axi_write(4'h8, 32'd12, 4'hF);
        repeat (14) step();
        n = 0;
        for (int k = 0; k < 12; k++) begin
            n += pwm_out ? 1 : 0;
            step();
        end
        chk("duty_gt_period_high", n, 32'd12);

        // PERIOD=0 -> constant low, counter parked
        axi_write(4'h4, 32'd0, 4'hF);
        repeat (14) step();
        n = 0;
        for (int k = 0; k < 6; k++) begin
            n += (pwm_out || period_done) ? 1 : 0;
            step();
        end
        chk("period0_low", n, 32'd0);
        axi_read(4'hC, rd); chk("period0_count", rd, 32'd0);

        // Reset with a buffered AW and PWM running
        axi_write(4'h4, 32'd10, 4'hF);
        axi_write(4'h8, 32'd3, 4'hF);
        repeat (5) step();
        bready = 1'b0;
        awaddr = 4'h4; awvalid = 1'b1; wvalid = 1'b0;
        step();
        awvalid = 1'b0;
        rstn = 1'b0;
        step();
        chk("mrst_awready", {31'd0, awready}, 32'd0);
        chk("mrst_wready", {31'd0, wready}, 32'd0);
        chk("mrst_arready", {31'd0, arready}, 32'd0);
        chk("mrst_bvalid", {31'd0, bvalid}, 32'd0);
        chk("mrst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("mrst_pwm", {31'd0, pwm_out}, 32'd0);
        chk("mrst_pd", {31'd0, period_done}, 32'd0);
        step();
        rstn = 1'b1;
        step();
        chk("mrst_rel_awready", {31'd0, awready}, 32'd1);
        chk("mrst_rel_no_b", {31'd0, bvalid}, 32'd0);
        axi_write(4'h8, 32'd5, 4'hF);
        axi_read(4'h8, rd); chk("mrst_new_duty", rd, 32'd5);
        axi_read(4'h4, rd); chk("mrst_period_clear", rd, 32'd0);
        axi_read(4'h0, rd); chk("mrst_ctrl_clear", rd, 32'd0);
        axi_write(4'h4, 32'd4, 4'hF);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            n += pwm_out ? 1 : 0;
            step();
        end
        chk("mrst_pwm_idle", n, 32'd0);
        axi_read(4'hC, rd); chk("mrst_count_idle", rd, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pwm_axi_slave.md
# pwm_axi_slave

AXI4-Lite responder exposing four 32-bit registers that control a single-channel PWM generator. It is the slave end of the S00_AXI link driven by the block-design AXI master (VIP in simulation, PS in hardware), and it drives one `pwm_out` pin. Period and duty writes are shadowed and take effect only at a PWM period boundary, so the output never glitches.

## Interface
- `C_S_AXI_DATA_WIDTH`, 32: AXI data width. Only 32 is supported.
- `C_S_AXI_ADDR_WIDTH`, 4: AXI byte-address width. Bits [3:2] select the register.
- `S_AXI_ACLK` in 1: the single clock. Every flop is on its rising edge.
- `S_AXI_ARESETN` in 1: reset, synchronous and active-low.
- `S_AXI_AWADDR` in 4 / `S_AXI_AWPROT` in 3 / `S_AXI_AWVALID` in 1 / `S_AXI_AWREADY` out 1: write-address channel. AWPROT is ignored.
- `S_AXI_WDATA` in 32 / `S_AXI_WSTRB` in 4 / `S_AXI_WVALID` in 1 / `S_AXI_WREADY` out 1: write-data channel.
- `S_AXI_BRESP` out 2 / `S_AXI_BVALID` out 1 / `S_AXI_BREADY` in 1: write-response channel.
- `S_AXI_ARADDR` in 4 / `S_AXI_ARPROT` in 3 / `S_AXI_ARVALID` in 1 / `S_AXI_ARREADY` out 1: read-address channel.
- `S_AXI_RDATA` out 32 / `S_AXI_RRESP` out 2 / `S_AXI_RVALID` out 1 / `S_AXI_RREADY` in 1: read-data channel.
- `pwm_out` out 1: PWM output.
- `period_done` out 1: one-cycle pulse on the last count of each active period.

## Operation
- **Register map**
  - 0x0 CTRL: bit0 `EN`. Bits [31:1] read as 0.
  - 0x4 PERIOD: R/W, pending period.
  - 0x8 DUTY: R/W, pending duty.
  - 0xC COUNT: read-only, current counter value. Writes complete with OKAY and have no effect.
- **Byte strobes:** each WSTRB bit gates its byte lane for CTRL, PERIOD and DUTY.
- **Responses:** BRESP and RRESP are always 2'b00 (OKAY). There is no error decode.
- **Write path**
  - AW and W are accepted independently, in either order, and each is held in a one-entry buffer.
  - `AWREADY = !aw_held && !BVALID`; `WREADY = !w_held && !BVALID`.
  - The register write fires on the edge where both an address and data are available, whether buffered or handshaking in the same cycle. That same edge sets BVALID and clears both buffers.
- **Read path**
  - `ARREADY = !RVALID`.
  - An AR handshake registers RDATA and sets RVALID on the same edge.
  - RVALID and RDATA hold until RREADY.
- **PWM core**
  - Holds `period_act`, `duty_act` and a 32-bit counter `cnt`.
  - When `EN=0`: `cnt=0`, `pwm_out=0`, and the shadows load continuously from PERIOD/DUTY.
  - When `EN=1` and `period_act=0`: `cnt` holds at 0, `pwm_out=0`, and the shadows still reload every cycle.
  - Otherwise `cnt` counts 0..`period_act`-1 and wraps.
  - `pwm_out = (cnt < duty_act)`, registered. `duty_act >= period_act` therefore gives a constant high.
  - On the cycle where `cnt = period_act-1`: `period_done` pulses, the shadows load from PERIOD/DUTY, and `cnt` goes to 0.

## Timing
- **Reset:** on a rising edge with `S_AXI_ARESETN=0`:
  - All of AWREADY, WREADY, ARREADY, BVALID, RVALID, RDATA, `pwm_out`, `period_done` = 0.
  - CTRL, PERIOD, DUTY, COUNT and both shadows = 0. Buffered AW/W entries are dropped.
  - Reset mid-transaction discards the transaction. No response is issued.
- **First cycle after reset release:** AWREADY, WREADY and ARREADY are 1.
- **Write latency:** AW and W handshake together in cycle N → register updated and BVALID=1 in N+1. AW in N, W in N+k → BVALID in N+k+1.
- **Read latency:** AR handshake in N → RVALID in N+1.
- **Read/write collision:** a read and a write to the same register in the same cycle returns the old value.
- **Back-pressure:** while BVALID=1 and BREADY=0, AWREADY and WREADY stay 0.
- **PWM start:** `EN` set in cycle N → `cnt=0` in N+1 and `pwm_out` is valid from N+2 (one registered stage).
- **Mid-period writes:** a new PERIOD/DUTY written mid-period takes effect on the first count after the wrap.
- **EN cleared mid-period:** forces `cnt=0` and `pwm_out=0` on the next edge.

## Structure
- **Package `pwm_axi_pkg`:**
  - Register offset constants: `REG_CTRL=2'd0`, `REG_PERIOD=2'd1`, `REG_DUTY=2'd2`, `REG_COUNT=2'd3`.
  - `CTRL_EN_BIT=0`.
  - `RESP_OKAY=2'b00`.
- **Sub-module `pwm_core`:** counter, shadow registers, `pwm_out` and `period_done`. Its inputs are `en`, `period` and `duty`; it outputs `cnt`.
- **Top module:** AXI FSM-free handshake logic and the register file.

## Test plan
1. **Write/readback:** write 0x1, 0xA, 0x3, 0xFFFF to 0x0/0x4/0x8/0xC, then read all four → 0x1, 0xA, 0x3, and COUNT in 0..9 (never 0xFFFF). All responses OKAY.
2. **Byte strobes:** PERIOD=0x11223344, then write 0xAABBCCDD with WSTRB=4'b0101 → readback 0x11BB33DD.
3. **Out-of-order channels:** AWVALID 3 cycles before WVALID → BVALID exactly 1 cycle after the W handshake. Hold BREADY=0 for 4 cycles → AWREADY and WREADY stay 0 until B completes.
4. **Waveform and mid-period update:** PERIOD=10, DUTY=3, EN=1 → `pwm_out` high 3 / low 7 and `period_done` every 10 cycles. Write DUTY=7 at `cnt=5` → the current period stays at 3 high, the next is 7 high.
5. **Boundary values:** DUTY=12 with PERIOD=10 → constant high. PERIOD=0 → constant low with `cnt=0`.
6. **Reset mid-operation:** assert reset during a pending AW (no W yet) with PWM running → all outputs 0. After release, a fresh write completes normally and the PWM is idle until EN is rewritten.
